// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: state encoding, drain depth
// and the hard-wired zero register index.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int         DRAIN_CYCLES_DEF = 3;
  localparam logic [4:0] R0               = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare between the load destination in EX and the
// source registers of the instruction sitting in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int NB_REG = 5
) (
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  input  logic              id_uses_rt,
  output logic              hazard
);

  // A load into r0 never creates a dependency since r0 reads as zero.
  assign hazard = ex_mem_read & (ex_rt != NB_REG'(R0)) &
                  ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the 5-stage pipeline: run/stall/flush controls,
// HALT drain, debug single-step and the executed-cycle counter.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NB_REG       = 5,
  parameter int NB_CYCLES    = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_mode_step,
  input  logic                 i_step,
  input  logic                 i_halt_detected,
  input  logic                 i_branch_taken,
  input  logic                 i_ex_mem_read,
  input  logic [NB_REG-1:0]    i_ex_rt,
  input  logic [NB_REG-1:0]    i_id_rs,
  input  logic [NB_REG-1:0]    i_id_rt,
  input  logic                 i_id_uses_rt,
  output logic                 o_pipe_en,
  output logic                 o_pc_write,
  output logic                 o_if_id_write,
  output logic                 o_id_ex_bubble,
  output logic                 o_if_id_flush,
  output logic                 o_halted,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  localparam int NB_DRAIN = $clog2(DRAIN_CYCLES + 1);

  state_t                 state_r;
  logic [NB_DRAIN-1:0]    drain_cnt_r;
  logic [NB_CYCLES-1:0]   cycle_count_r;
  logic                   step_q_r;
  logic                   hazard_s;
  logic                   step_pulse_s;
  logic                   en_raw_s;

  hazard_detect #(.NB_REG(NB_REG)) u_hazard (
    .ex_mem_read (i_ex_mem_read),
    .ex_rt       (i_ex_rt),
    .id_rs       (i_id_rs),
    .id_rt       (i_id_rt),
    .id_uses_rt  (i_id_uses_rt),
    .hazard      (hazard_s)
  );

  assign step_pulse_s = i_step & ~step_q_r;
  assign en_raw_s     = i_mode_step ? step_pulse_s : 1'b1;

  // Control outputs decoded from state and live inputs so stalls act this cycle.
  always_comb begin
    o_pipe_en      = 1'b0;
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_if_id_flush  = 1'b0;
    o_halted       = 1'b0;
    o_cycle_count  = '0;
    if (i_reset) begin
      o_pipe_en = 1'b0;
    end else begin
      o_cycle_count = cycle_count_r;
      case (state_r)
        ST_RUN: begin
          o_pipe_en = en_raw_s;
          if (!en_raw_s) begin
            o_pipe_en = 1'b0;
          end else if (hazard_s) begin
            o_id_ex_bubble = 1'b1;
          end else if (i_halt_detected) begin
            o_pc_write = 1'b0;
          end else begin
            o_pc_write    = 1'b1;
            o_if_id_write = 1'b1;
            o_if_id_flush = i_branch_taken;
          end
        end
        ST_DRAIN: begin
          o_pipe_en      = en_raw_s;
          o_id_ex_bubble = en_raw_s;
        end
        ST_HALTED: begin
          o_halted = 1'b1;
        end
        default: begin
          o_pipe_en = 1'b0;
        end
      endcase
    end
  end

  // Sequencer state, drain countdown, step edge register and cycle counter.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= ST_RUN;
      drain_cnt_r   <= '0;
      cycle_count_r <= '0;
      step_q_r      <= 1'b0;
    end else begin
      step_q_r <= i_step;
      if (o_pipe_en && (cycle_count_r != {NB_CYCLES{1'b1}})) begin
        cycle_count_r <= cycle_count_r + NB_CYCLES'(1);
      end
      case (state_r)
        ST_RUN: begin
          if (o_pipe_en && !hazard_s && i_halt_detected) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= NB_DRAIN'(DRAIN_CYCLES);
          end
        end
        ST_DRAIN: begin
          if (o_pipe_en) begin
            drain_cnt_r <= drain_cnt_r - NB_DRAIN'(1);
            if (drain_cnt_r == NB_DRAIN'(1)) begin
              state_r <= ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          state_r <= ST_HALTED;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode_step, step, halt, br, mr, ur;
  logic [4:0]  ex_rt, rs, rt;
  logic        pipe_en, pc_write, if_id_write, bubble, flush, halted;
  logic [31:0] count;

  int vectors = 0;
  int miscompares = 0;

  pipeline_ctrl dut (
    .i_clock(clk), .i_reset(rst), .i_mode_step(mode_step), .i_step(step),
    .i_halt_detected(halt), .i_branch_taken(br), .i_ex_mem_read(mr),
    .i_ex_rt(ex_rt), .i_id_rs(rs), .i_id_rt(rt), .i_id_uses_rt(ur),
    .o_pipe_en(pipe_en), .o_pc_write(pc_write), .o_if_id_write(if_id_write),
    .o_id_ex_bubble(bubble), .o_if_id_flush(flush), .o_halted(halted),
    .o_cycle_count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mr;
    logic [4:0] ex_rt, rs, rt;
    logic       ur, br;
    logic [3:0] exp;   // {pc_write, if_id_write, bubble, flush}
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mode_step = 1'b0; step = 1'b0; halt = 1'b0; br = 1'b0; mr = 1'b0; ur = 1'b0;
    ex_rt = 5'd0; rs = 5'd0; rt = 5'd0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_pipe_en"}, 64'(pipe_en), 64'd0);
    chk({nm, "_ctrl"}, 64'({pc_write, if_id_write, bubble, flush}), 64'd0);
    chk({nm, "_halted"}, 64'(halted), 64'd0);
    chk({nm, "_count"}, 64'(count), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Behavioural reference model
  bit      m_halted;
  int      m_drain_left;
  longint  m_count;
  bit      m_prev_step;

  task automatic model_reset();
    m_halted = 1'b0; m_drain_left = 0; m_count = 0; m_prev_step = 1'b0;
  endtask

  initial begin
    int pulses;
    bit hz, en, running, e_pc, e_bub, e_fl;
    idle_inputs();
    rst = 1'b1;
    tbl[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 4'b0010};
    tbl[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 4'b1100};
    tbl[2] = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 4'b1100};
    tbl[3] = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 4'b0010};
    tbl[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 4'b1100};
    tbl[5] = '{1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 4'b1101};
    tbl[6] = '{1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b1, 4'b0010};
    tbl[7] = '{1'b1, 5'd7, 5'd3, 5'd4, 1'b1, 1'b1, 4'b1101};

    // Reset state, then free-running for 10 cycles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("run_pipe_en", 64'(pipe_en), 64'd1);
      chk("run_pc_write", 64'(pc_write), 64'd1);
      tick();
    end
    chk("run_count10", 64'(count), 64'd10);

    // Directed vector table in RUN, continuous mode
    for (int i = 0; i < 8; i++) begin
      mr = tbl[i].mr; ex_rt = tbl[i].ex_rt; rs = tbl[i].rs; rt = tbl[i].rt;
      ur = tbl[i].ur; br = tbl[i].br;
      #1;
      chk($sformatf("tbl%0d_ctrl", i), 64'({pc_write, if_id_write, bubble, flush}), 64'(tbl[i].exp));
      chk($sformatf("tbl%0d_pipe_en", i), 64'(pipe_en), 64'd1);
      tick();
    end
    idle_inputs();
    #1;
    chk("tbl_count", 64'(count), 64'd18);

    // HALT (with simultaneous branch) then drain, halt and reset recovery
    do_reset();
    halt = 1'b1; br = 1'b1;
    #1;
    chk("halt_ctrl", 64'({pc_write, if_id_write, bubble, flush}), 64'd0);
    chk("halt_pipe_en", 64'(pipe_en), 64'd1);
    tick();
    halt = 1'b0; br = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("drain_ctrl", 64'({pc_write, if_id_write, bubble, flush}), 64'b0010);
      chk("drain_pipe_en", 64'(pipe_en), 64'd1);
      chk("drain_halted", 64'(halted), 64'd0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      step = ~step;
      #1;
      chk("halted_flag", 64'(halted), 64'd1);
      chk("halted_pipe_en", 64'(pipe_en), 64'd0);
      chk("halted_count", 64'(count), 64'd4);
      tick();
    end
    step = 1'b0;
    do_reset();
    chk("post_halt_pipe_en", 64'(pipe_en), 64'd1);
    chk("post_halt_halted", 64'(halted), 64'd0);
    chk("post_halt_count", 64'(count), 64'd0);

    // Debug step mode: held level gives one step, then two more edges
    do_reset();
    mode_step = 1'b1;
    #1;
    chk("step_idle_pipe_en", 64'(pipe_en), 64'd0);
    chk("step_idle_pc", 64'(pc_write), 64'd0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step = (i < 5) || (i == 6) || (i == 8);
      #1;
      pulses += int'(pipe_en);
      tick();
    end
    step = 1'b0;
    chk("step_pulses", 64'(pulses), 64'd3);
    chk("step_count", 64'(count), 64'd3);
    mode_step = 1'b0;

    // Asynchronous reset mid-drain
    do_reset();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    #2;
    rst = 1'b0;
    #1;
    chk("async_rel_ctrl", 64'({pc_write, if_id_write, bubble, flush}), 64'b1100);
    chk("async_rel_pipe_en", 64'(pipe_en), 64'd1);
    chk("async_rel_halted", 64'(halted), 64'd0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      if (m_halted && ($urandom_range(0, 3) == 0)) begin
        idle_inputs();
        do_reset();
        model_reset();
      end
      mode_step = ($urandom_range(0, 3) == 0);
      step = $urandom_range(0, 1);
      halt = ($urandom_range(0, 19) == 0);
      br = $urandom_range(0, 1);
      mr = $urandom_range(0, 1);
      ur = $urandom_range(0, 1);
      ex_rt = 5'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      hz = mr && (ex_rt != 5'd0) && ((ex_rt == rs) || (ur && (ex_rt == rt)));
      en = !m_halted && (mode_step ? (step && !m_prev_step) : 1'b1);
      running = !m_halted && (m_drain_left == 0);
      e_pc = en && running && !hz && !halt;
      e_bub = en && ((m_drain_left > 0) || (running && hz));
      e_fl = e_pc && br;
      #1;
      chk("rnd_pipe_en", 64'(pipe_en), 64'(en));
      chk("rnd_ctrl", 64'({pc_write, if_id_write, bubble, flush}),
          64'({e_pc, e_pc, e_bub, e_fl}));
      chk("rnd_halted", 64'(halted), 64'(m_halted));
      chk("rnd_count", 64'(count), 64'(m_count));
      m_prev_step = step;
      if (en) begin
        m_count++;
        if (m_drain_left > 0) begin
          m_drain_left--;
          if (m_drain_left == 0) m_halted = 1'b1;
        end else if (!hz && halt) begin
          m_drain_left = 3;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencer for the 5-stage MIPS pipeline.
- Generates the pipeline enable, PC/IF-ID write, ID-EX bubble and IF-ID flush controls around the ID stage (decode, sign extension, register read).
- Handles load-use stalls, branch flushes, HALT drain and debug single-step.
- Sits between the debug unit and all pipeline registers.

Parameters:
- NB_REG, 5, register address width.
- NB_CYCLES, 32, cycle counter width.
- DRAIN_CYCLES, 3, pipe_en cycles after HALT decode before halted (EX, MEM, WB).

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_mode_step  in  1  0 = continuous run, 1 = debug step mode.
- i_step  in  1  step request level from debug unit; rising edge = one step.
- i_halt_detected  in  1  ID stage decoded a HALT opcode.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- i_ex_mem_read  in  1  instruction in EX is a load.
- i_ex_rt  in  NB_REG  load destination register in EX.
- i_id_rs  in  NB_REG  rs of instruction in ID.
- i_id_rt  in  NB_REG  rt of instruction in ID.
- i_id_uses_rt  in  1  ID instruction reads rt (R-type, store, beq/bne).
- o_pipe_en  out  1  global enable for all pipeline registers.
- o_pc_write  out  1  PC update enable.
- o_if_id_write  out  1  IF/ID register load enable.
- o_id_ex_bubble  out  1  force NOP into ID/EX.
- o_if_id_flush  out  1  clear IF/ID to NOP.
- o_halted  out  1  pipeline halted and drained.
- o_cycle_count  out  NB_CYCLES  executed (enabled) cycles.

Behaviour:
- Reset:
  - Asynchronous, active-high; i_reset=1 forces state RUN, drain_cnt=0, cycle_count=0, step_q=0.
  - While i_reset=1, all outputs are forced 0.
  - Reset mid-drain or while HALTED returns to RUN immediately.
- Step edge detection:
  - step_q registers i_step each clock.
  - step_pulse = i_step & ~step_q (one cycle per rising edge).
  - A held i_step yields exactly one step.
- States: RUN, DRAIN, HALTED.
- en_raw = i_mode_step ? step_pulse : 1.
- o_pipe_en = en_raw in RUN/DRAIN; 0 in HALTED.
- Load-use hazard (combinational):
  - hazard = i_ex_mem_read & (i_ex_rt != 0) & ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt))).
- RUN, o_pipe_en=1, default: pc_write=1, if_id_write=1, bubble=0, flush=0.
- RUN, hazard=1:
  - pc_write=0, if_id_write=0, bubble=1.
  - Branch flush and HALT entry are suppressed; the instruction is re-evaluated next cycle.
  - Stall length is exactly 1 enabled cycle.
- RUN, hazard=0, i_branch_taken=1: flush=1.
- RUN, hazard=0, i_halt_detected=1:
  - Go to DRAIN next clock; drain_cnt loads DRAIN_CYCLES.
  - pc_write=0 and if_id_write=0 this cycle.
  - If i_branch_taken is also 1, HALT has priority and flush=0.
- DRAIN:
  - pc_write=0, if_id_write=0, bubble=1, flush=0.
  - drain_cnt decrements on each o_pipe_en cycle.
  - When drain_cnt==1 and o_pipe_en=1, go to HALTED.
- HALTED:
  - o_halted=1, all enables 0.
  - Exits only via reset; i_step is ignored.
- o_pipe_en=0 (step mode with no pulse, or HALTED):
  - pc_write, if_id_write, bubble and flush are all 0.
  - State and drain_cnt hold.
- cycle_count:
  - +1 on every clock with o_pipe_en=1.
  - Saturates at all-ones (no wrap).
  - Holds in HALTED.
- Registered state: state, drain_cnt, cycle_count, step_q.
- Control outputs are combinational from state and inputs, so a stall takes effect in the same cycle.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding (RUN=2'd0, DRAIN=2'd1, HALTED=2'd2);
  - DRAIN_CYCLES default;
  - R0 constant (5'd0).
- Sub-module hazard_detect (purely combinational load-use compare) is instantiated once.
- FSM, step edge detection and counters stay in the top module.

Test Plan:
- Reset, then mode_step=0 for 10 cycles with no hazards:
  - pipe_en=1, pc_write=1 every cycle;
  - cycle_count=10.
- Load-use, ex_mem_read=1, ex_rt=5, id_rs=5:
  - exactly one cycle of pc_write=0, if_id_write=0, bubble=1;
  - repeat with ex_rt=0 -> no stall;
  - repeat with id_rt=5, id_uses_rt=0 -> no stall.
- Branch, branch_taken=1, no hazard:
  - flush=1 for that cycle;
  - with hazard in the same cycle -> flush=0, bubble=1.
- HALT, halt_detected=1 at cycle N:
  - DRAIN for 3 cycles;
  - o_halted=1 from cycle N+4;
  - pipe_en=0 and cycle_count frozen afterwards;
  - i_reset pulse then returns to RUN with count=0.
- Step mode, mode_step=1, i_step held high 5 cycles, then low, then 2 more edges:
  - exactly 3 pipe_en pulses;
  - cycle_count=3.
- Reset asserted asynchronously mid-DRAIN (between clock edges):
  - all outputs 0 immediately;
  - RUN after deassertion.
